// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - valid/ready command front-end for the 5-bit ALU with settle timer and response register
// Optional sticky carry flag is enabled by defining ALU_CMD_STICKY_EN.
module alu_cmd_issuer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_a,
    input  logic [4:0]       cmd_b,
    input  logic             cmd_op,
    output logic [4:0]       alu_a,
    output logic [4:0]       alu_b,
    output logic             alu_op,
    input  logic [4:0]       alu_r,
    input  logic             alu_cf,
    input  logic             alu_sf,
    input  logic             alu_zf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_r,
    output logic             rsp_cf,
    output logic             rsp_sf,
    output logic             rsp_zf,
    output logic [CNT_W-1:0] op_count,
    input  logic             sticky_clr,
    output logic             sticky_cf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [4:0]         alu_a_q, alu_a_d;
    logic [4:0]         alu_b_q, alu_b_d;
    logic               alu_op_q, alu_op_d;
    logic [4:0]         rsp_r_q, rsp_r_d;
    logic               rsp_cf_q, rsp_cf_d;
    logic               rsp_sf_q, rsp_sf_d;
    logic               rsp_zf_q, rsp_zf_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic               capture;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_r_d     = rsp_r_q;
        rsp_cf_d    = rsp_cf_q;
        rsp_sf_d    = rsp_sf_q;
        rsp_zf_d    = rsp_zf_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    cnt_d    = 4'(SETTLE_CYCLES - 1);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    capture     = 1'b1;
                    rsp_r_d     = alu_r;
                    rsp_cf_d    = alu_cf;
                    rsp_sf_d    = alu_sf;
                    rsp_zf_d    = alu_zf;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= 5'd0;
            alu_b_q     <= 5'd0;
            alu_op_q    <= 1'b0;
            rsp_r_q     <= 5'd0;
            rsp_cf_q    <= 1'b0;
            rsp_sf_q    <= 1'b0;
            rsp_zf_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_r_q     <= rsp_r_d;
            rsp_cf_q    <= rsp_cf_d;
            rsp_sf_q    <= rsp_sf_d;
            rsp_zf_q    <= rsp_zf_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

`ifdef ALU_CMD_STICKY_EN
    logic sticky_q, sticky_d;

    // A capture with carry in the same cycle as a clear leaves the flag set.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
        if (capture && alu_cf) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_cf = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = sticky_clr | capture;
    assign sticky_cf     = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_cf    = rsp_cf_q;
    assign rsp_sf    = rsp_sf_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_valid = rsp_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - scoreboard bench for alu_cmd_issuer at two parameter settings
module tb_alu_cmd_issuer;

    typedef struct {
        logic [4:0] r;
        logic       cf;
        logic       sf;
        logic       zf;
        int         cnt;
        int         due;
    } exp_t;

`ifdef ALU_CMD_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic cmd_valid = 1'b0;
    logic [4:0] cmd_a = 5'd0;
    logic [4:0] cmd_b = 5'd0;
    logic cmd_op = 1'b0;
    logic rsp_ready = 1'b1;
    logic sticky_clr = 1'b0;

    logic       d1_cmd_ready, d1_alu_op, d1_rsp_valid, d1_rsp_cf, d1_rsp_sf, d1_rsp_zf, d1_sticky;
    logic [4:0] d1_alu_a, d1_alu_b, d1_rsp_r, d1_alu_r;
    logic       d1_alu_cf, d1_alu_sf, d1_alu_zf;
    logic [7:0] d1_op_count;
    logic       d3_cmd_ready, d3_alu_op, d3_rsp_valid, d3_rsp_cf, d3_rsp_sf, d3_rsp_zf, d3_sticky;
    logic [4:0] d3_alu_a, d3_alu_b, d3_rsp_r, d3_alu_r;
    logic       d3_alu_cf, d3_alu_sf, d3_alu_zf;
    logic [1:0] d3_op_count;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int exp_cnt1 = 0;
    int exp_cnt3 = 0;
    exp_t sb[$];
    logic seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: {cf, sf, zf, r}; CF is any bit shifted out the top.
    function automatic logic [7:0] alu_model(input logic [4:0] a, input logic [4:0] b, input logic op);
        logic [9:0] wide;
        logic [4:0] r;
        logic       cf;
        if (op) begin
            wide = {5'd0, a} << b;
            r    = wide[4:0];
            cf   = |wide[9:5];
        end else begin
            r  = ~a;
            cf = 1'b0;
        end
        return {cf, r[4], (r == 5'd0), r};
    endfunction

    assign {d1_alu_cf, d1_alu_sf, d1_alu_zf, d1_alu_r} = alu_model(d1_alu_a, d1_alu_b, d1_alu_op);
    assign {d3_alu_cf, d3_alu_sf, d3_alu_zf, d3_alu_r} = alu_model(d3_alu_a, d3_alu_b, d3_alu_op);

    alu_cmd_issuer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(d1_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
        .alu_r(d1_alu_r), .alu_cf(d1_alu_cf), .alu_sf(d1_alu_sf), .alu_zf(d1_alu_zf),
        .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_r(d1_rsp_r), .rsp_cf(d1_rsp_cf), .rsp_sf(d1_rsp_sf), .rsp_zf(d1_rsp_zf),
        .op_count(d1_op_count), .sticky_clr(sticky_clr), .sticky_cf(d1_sticky)
    );

    alu_cmd_issuer #(.SETTLE_CYCLES(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & sel), .cmd_ready(d3_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_op(d3_alu_op),
        .alu_r(d3_alu_r), .alu_cf(d3_alu_cf), .alu_sf(d3_alu_sf), .alu_zf(d3_alu_zf),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_r(d3_rsp_r), .rsp_cf(d3_rsp_cf), .rsp_sf(d3_rsp_sf), .rsp_zf(d3_rsp_zf),
        .op_count(d3_op_count), .sticky_clr(sticky_clr), .sticky_cf(d3_sticky)
    );

    wire       m_cmd_ready = sel ? d3_cmd_ready : d1_cmd_ready;
    wire       m_rsp_valid = sel ? d3_rsp_valid : d1_rsp_valid;
    wire [4:0] m_rsp_r     = sel ? d3_rsp_r : d1_rsp_r;
    wire       m_rsp_cf    = sel ? d3_rsp_cf : d1_rsp_cf;
    wire       m_rsp_sf    = sel ? d3_rsp_sf : d1_rsp_sf;
    wire       m_rsp_zf    = sel ? d3_rsp_zf : d1_rsp_zf;
    wire [7:0] m_op_count  = sel ? {6'd0, d3_op_count} : d1_op_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic op,
                         input logic [4:0] er, input logic ecf, input logic esf, input logic ezf);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!m_cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("issue_timeout", 32'(guard), 32'd0);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            e.r = er; e.cf = ecf; e.sf = esf; e.zf = ezf;
            e.cnt = sel ? (exp_cnt3 % 4) : (exp_cnt1 % 256);
            e.due = cyc + (sel ? 3 : 1);
            sb.push_back(e);
            if (sel) exp_cnt3++; else exp_cnt1++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_rsp_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                else check("rsp_latency", 32'(cyc), 32'(sb[0].due));
            end
            if (m_rsp_valid && rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_r", 32'(m_rsp_r), 32'(e.r));
                check("rsp_cf", 32'(m_rsp_cf), 32'(e.cf));
                check("rsp_sf", 32'(m_rsp_sf), 32'(e.sf));
                check("rsp_zf", 32'(m_rsp_zf), 32'(e.zf));
                check("op_count_pre", 32'(m_op_count), 32'(e.cnt));
                seen = 1'b0;
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || !m_cmd_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(d1_cmd_ready), 32'd1);
        check("rst_alu", 32'({d1_alu_a, d1_alu_b, d1_alu_op}), 32'd0);
        check("rst_rsp", 32'({d1_rsp_valid, d1_rsp_r, d1_rsp_cf, d1_rsp_sf, d1_rsp_zf}), 32'd0);
        check("rst_op_count", 32'(d1_op_count), 32'd0);
        check("rst_sticky", 32'(d1_sticky), 32'd0);
        rst = 1'b0;

        // Reset while the first command is still settling.
        @(negedge clk);
        cmd_a = 5'b10101; cmd_b = 5'd0; cmd_op = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("drive_cmd_ready", 32'(d1_cmd_ready), 32'd0);
        check("drive_alu_a", 32'(d1_alu_a), 32'b10101);
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(d1_rsp_valid), 32'd0);
        check("abort_alu_a", 32'(d1_alu_a), 32'd0);
        check("abort_cmd_ready", 32'(d1_cmd_ready), 32'd1);
        check("abort_op_count", 32'(d1_op_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_rsp", 32'(d1_rsp_valid), 32'd0);

        // NOT with the consumer always ready.
        rsp_ready = 1'b1;
        issue(5'b10101, 5'd0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("not_op_count", 32'(d1_op_count), 32'd1);
        check("not_cmd_ready", 32'(d1_cmd_ready), 32'd1);
        check("not_rsp_hold", 32'(d1_rsp_r), 32'b01010);

        issue(5'b11111, 5'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Backpressure with a stray command offered during RESP.
        rsp_ready = 1'b0;
        issue(5'b01010, 5'b00001, 1'b1, 5'b10100, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cmd_a = 5'b00111; cmd_b = 5'd2; cmd_op = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(d1_rsp_valid), 32'd1);
            check("bp_rsp", 32'({d1_rsp_r, d1_rsp_sf}), 32'({5'b10100, 1'b1}));
            check("bp_cmd_ready", 32'(d1_cmd_ready), 32'd0);
            check("bp_alu_a", 32'(d1_alu_a), 32'b01010);
            check("bp_op_count", 32'(d1_op_count), 32'd2);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_count", 32'(d1_op_count), 32'd3);
        wait_drain();

        // Sticky carry: set by a carry-out, held through a clean op, cleared by a pulse.
        issue(5'b11101, 5'b00001, 1'b1, 5'b11010, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("sticky_set", 32'(d1_sticky), 32'(STICKY_ON));
        issue(5'b00000, 5'd0, 1'b0, 5'b11111, 1'b0, 1'b1, 1'b0);
        wait_drain();
        check("sticky_hold", 32'(d1_sticky), 32'(STICKY_ON));
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check("sticky_clr", 32'(d1_sticky), 32'd0);

        // Longer settle time and a 2-bit counter that wraps.
        sel = 1'b1;
        issue(5'b00001, 5'd0, 1'b0, 5'b11110, 1'b0, 1'b1, 1'b0);
        issue(5'b00011, 5'd2, 1'b1, 5'b01100, 1'b0, 1'b0, 1'b0);
        issue(5'b10000, 5'd1, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1);
        issue(5'b01111, 5'd0, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0);
        issue(5'b00001, 5'd4, 1'b1, 5'b10000, 1'b0, 1'b1, 1'b0);
        wait_drain();
        check("wrap_final_count", 32'(d3_op_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
